dmem_store_buffer: RTL and testbench
====================================

# dmem_store_buffer

Write buffer between the store generator and the data memory port. It accepts the byte-lane-aligned store word and per-byte write enables produced each cycle by store generation, and queues them in a small FIFO. It drains the queue to a data memory with a request/acknowledge handshake, and stalls the core when the queue is full or when a load would overtake pending stores.

## Interface
- DEPTH, 4, number of buffered stores; power of two, minimum 2
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- daddr  input  32  store/load byte address from execute stage
- stdata  input  32  lane-aligned store data from store generation
- dwe  input  4  per-byte write enables from store generation; nonzero marks a store this cycle
- re  input  1  load request this cycle
- stall  output  1  core must hold the current instruction
- mem_req  output  1  write request to data memory
- mem_addr  output  32  word address of head entry, bits [1:0] always 0
- mem_wdata  output  32  head entry data
- mem_wstrb  output  4  head entry byte enables
- mem_ack  input  1  memory accepted the current write
- empty  output  1  no stores pending

## Operation
- Entry holds {daddr[31:2], stdata, dwe}. Circular FIFO with head pointer, tail pointer and occupancy count of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push when dwe != 4'b0000 and count < DEPTH. Tail entry is written, tail advances, count increments.
- Store with count == DEPTH is not pushed; stall = 1. Full blocks the push even if a pop occurs in the same cycle, so stall has no combinational path from mem_ack.
- Load ordering: re = 1 with count != 0 gives stall = 1. Loads proceed only once the buffer is empty. re = 1 with count == 0 gives stall = 0.
- stall = (dwe != 0 && count == DEPTH) || (re && count != 0). This is purely combinational from registered state and the current inputs.
- Memory side: mem_req = (count != 0). mem_addr, mem_wdata and mem_wstrb come directly from the head entry and stay stable while mem_req is high and mem_ack is low.
- Pop when mem_req && mem_ack: head advances and count decrements. mem_ack while mem_req = 0 is ignored.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Push into an empty buffer: entry is visible on the memory port the next cycle. Empty data never bypasses to the port.
- dwe == 0 and re == 0: no push and no stall.
- empty = (count == 0).

## Timing
- Reset, asynchronous on rst_n low: head = tail = count = 0. Outputs: mem_req = 0, empty = 1, stall = 0 absent inputs, mem_addr/mem_wdata/mem_wstrb = 0. Pending entries are discarded. Reset mid-handshake drops mem_req immediately.
- Minimum store-to-memory latency: 1 cycle from push edge to mem_req high.
- Throughput: one pop per cycle when mem_ack is held high. Back-to-back stores with ack tied high never fill the buffer.
- Load after store with a 1-cycle ack: store pushed at edge N, mem_req high in cycle N+1, popped at edge N+1. A load in cycle N+1 stalls, and its stall drops in cycle N+2.
- Entry storage needs no reset, but the head entry outputs must read 0 while empty after reset.

## Structure
- Shared package: store entry typedef (addr[29:0], data[31:0], strb[3:0]) and the DEPTH default constant.
- One sub-module, sbuf_fifo: a generic DEPTH×entry synchronous FIFO with push/pop/count/full/empty. dmem_store_buffer adds the stall logic and the memory handshake around it.

## Test plan
- Reset: rst_n low mid-operation with 2 entries pending. mem_req = 0, empty = 1 and count = 0 immediately; after release, no writes appear.
- Single store: daddr = 0x1006, stdata = 0x00AB0000, dwe = 4'b0100, mem_ack tied 1. Next cycle shows mem_addr = 0x1004, mem_wdata = 0x00AB0000, mem_wstrb = 4'b0100; one pop, then empty.
- Fill: mem_ack = 0 and 5 consecutive stores with DEPTH = 4. First 4 are pushed; the 5th raises stall and is held until ack. Writes drain in FIFO order with exact addr/data/strb.
- Load ordering: store to 0x2000, then re = 1 next cycle with mem_ack delayed 3 cycles. stall stays 1 until the cycle after the ack edge, then drops.
- Simultaneous push/pop at count = 2: count stays 2 and pointers wrap correctly across 10 cycles of continuous traffic. No lost or duplicated entries against the reference queue.
- Stray mem_ack while empty: no pointer movement and empty stays 1.

Source files
------------

// File: rtl/dmem_store_buffer_pkg.sv
// Shared types for the data-memory store buffer: the queued store entry and
// the default queue depth.
package dmem_store_buffer_pkg;

  localparam int SB_DEPTH = 4;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } sb_entry_t;

endpackage

// File: rtl/sbuf_fifo.sv
// Generic circular FIFO of store entries. Push is refused when full and pop is
// refused when empty, so callers may drive raw requests.
module sbuf_fifo
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  sb_entry_t                din_i,
  input  logic                     pop_i,
  output sb_entry_t                dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  sb_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // full is registered, so a same-cycle pop never frees a slot for the push
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (do_push) tail_d = tail_q + 1'b1;
    if (do_pop)  head_d = head_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; stale contents are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= din_i;
  end

  assign dout_o = empty_o ? '0 : mem_q[head_q];

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer between store generation and the data memory write port.
// Queues stores, drains them with req/ack, and stalls on full or load-after-store.
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] daddr,
  input  logic [31:0] stdata,
  input  logic [3:0]  dwe,
  input  logic        re,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  output logic        empty
);

  sb_entry_t              din, head;
  logic [$clog2(DEPTH):0] count;
  logic                   full, fifo_empty, store_v;
  logic                   unused_lo;

  assign store_v   = |dwe;
  assign din       = '{addr: daddr[31:2], data: stdata, strb: dwe};
  assign unused_lo = ^daddr[1:0];

  sbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (store_v),
    .din_i   (din),
    .pop_i   (mem_ack),
    .dout_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (fifo_empty)
  );

  // Loads wait for the buffer to drain so they never overtake pending stores.
  assign stall     = (store_v && full) || (re && !fifo_empty);
  assign mem_req   = (count != '0);
  assign empty     = fifo_empty;
  assign mem_addr  = {head.addr, 2'b00};
  assign mem_wdata = head.data;
  assign mem_wstrb = head.strb;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomized scoreboard bench for dmem_store_buffer against a queue-based model.
module tb_dmem_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] daddr = '0, stdata = '0;
  logic [3:0]  dwe = '0;
  logic        re = 1'b0, mem_ack = 1'b0;
  logic        stall, mem_req, empty;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  dmem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .daddr(daddr), .stdata(stdata), .dwe(dwe), .re(re),
    .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [67:0] sb[$];
  int   m_cnt = 0;
  logic acc = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: occupancy and ordering derived from the buffer's rules.
  always @(negedge clk) begin
    logic push, pop, exp_stall;
    if (!rst_n) begin
      m_cnt = 0; sb.delete(); acc = 1'b0;
    end else begin
      exp_stall = (dwe != 0 && m_cnt == DEPTH) || (re && m_cnt != 0);
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("mem_req", 32'(mem_req), 32'(m_cnt != 0));
      chk("empty", 32'(empty), 32'(m_cnt == 0));
      push = (dwe != 0) && (m_cnt < DEPTH);
      pop  = (m_cnt != 0) && mem_ack;
      acc  = push || (re && dwe == 0 && m_cnt == 0);
      if (push) sb.push_back({daddr & 32'hFFFF_FFFC, stdata, dwe});
      m_cnt = m_cnt + int'(push) - int'(pop);
    end
  end

  // Monitor: compares every accepted memory write against the scoreboard.
  logic        hold = 1'b0;
  logic [67:0] prev;
  always @(negedge clk) begin
    logic [67:0] e;
    if (!rst_n) hold = 1'b0;
    else begin
      if (hold && mem_req) chk("port_stable", 32'({mem_addr, mem_wdata, mem_wstrb} == prev), 32'd1);
      if (mem_req && mem_ack) begin
        if (sb.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("mem_addr", mem_addr, e[67:36]);
          chk("mem_wdata", mem_wdata, e[35:4]);
          chk("mem_wstrb", 32'(mem_wstrb), 32'(e[3:0]));
        end
      end
      hold = mem_req && !mem_ack;
      prev = {mem_addr, mem_wdata, mem_wstrb};
    end
  end

  task automatic idle(input int n);
    dwe = '0; re = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Core side: hold the store until the buffer takes it.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int k = 0;
    daddr = a; stdata = d; dwe = s; re = 1'b0;
    do begin @(posedge clk); k++; end while (!acc && k < 50);
    if (!acc) chk("store_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic load(input logic [31:0] a);
    int k = 0;
    daddr = a; dwe = '0; re = 1'b1;
    do begin @(posedge clk); k++; end while (!acc && k < 50);
    if (!acc) chk("load_timeout", 32'd0, 32'd1);
    #1; re = 1'b0;
  endtask

  initial begin
    bit done;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);

    // single store, ack tied high
    mem_ack = 1'b1;
    store(32'h1006, 32'h00AB_0000, 4'b0100);
    idle(4);

    // fill with ack low, fifth store stalls until drain starts
    fork
      begin
        store(32'h100, 32'h1111_1111, 4'hF);
        store(32'h105, 32'h2222_2222, 4'h2);
        store(32'h10A, 32'h3333_3333, 4'h4);
        store(32'h10F, 32'h4444_4444, 4'h8);
        store(32'h110, 32'h5555_5555, 4'h3);
        idle(1);
      end
      begin mem_ack = 1'b0; repeat (9) @(posedge clk); #1 mem_ack = 1'b1; end
    join
    idle(8);

    // load behind a store, ack delayed 3 cycles
    fork
      begin store(32'h2000, 32'hDEAD_BEEF, 4'hF); load(32'h2004); idle(1); end
      begin mem_ack = 1'b0; repeat (4) @(posedge clk); #1 mem_ack = 1'b1; end
    join
    idle(4);

    // concurrent push/pop at occupancy 2
    mem_ack = 1'b0;
    store(32'h3000, 32'hA0, 4'h1);
    store(32'h3004, 32'hA1, 4'h2);
    mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) store(32'h3008 + 32'(4*i), $urandom, 4'(1 + $urandom_range(0, 14)));
    idle(6);

    // stray ack while empty
    mem_ack = 1'b1;
    idle(4);
    chk("stray_empty", 32'(empty), 32'd1);

    // reset mid-operation with 2 pending
    mem_ack = 1'b0;
    store(32'h4000, 32'hCAFE_0000, 4'hC);
    store(32'h4004, 32'h0000_F00D, 4'h3);
    idle(1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_empty", 32'(empty), 32'd1);
    chk("rst_mid_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    mem_ack = 1'b1;
    idle(5);

    // randomized traffic with random ack
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          case ($urandom_range(0, 3))
            0, 1: store($urandom, $urandom, 4'($urandom_range(1, 15)));
            2:    load($urandom);
            default: idle(1);
          endcase
        end
        idle(1);
        done = 1'b1;
      end
      begin
        while (!done) begin @(posedge clk); #1 mem_ack = ($urandom_range(0, 2) != 0); end
      end
    join
    mem_ack = 1'b1;
    idle(10);
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
